// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and the default bit period
// (50 MHz / 9600 baud) used by both the transmitter and the receiver.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 5208;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  localparam logic [2:0] ENC_IDLE   = 3'd0;
  localparam logic [2:0] ENC_START  = 3'd1;
  localparam logic [2:0] ENC_DATA   = 3'd2;
  localparam logic [2:0] ENC_PARITY = 3'd3;
  localparam logic [2:0] ENC_STOP   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = ENC_IDLE,
    ST_START  = ENC_START,
    ST_DATA   = ENC_DATA,
    ST_PARITY = ENC_PARITY,
    ST_STOP   = ENC_STOP
  } uart_state_t;

  // Parity bit that makes the count of ones over data+parity even (EVEN) or odd (ODD).
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (mode == PARITY_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period down-counter: bit_tick pulses in the last cycle of every CLKS_PER_BIT-cycle bit
// and the counter reloads itself; load restarts a bit period, en low freezes the count.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic load,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (en) begin
      cnt <= (cnt == '0) ? RELOAD : cnt - 1'b1;
    end
  end

  assign bit_tick = en && !load && (cnt == '0);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start, 8 data bits LSB first, optional parity, stop; start bit leaves
// one cycle after tx_start is accepted. tx_start is ignored while busy (no queuing).
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY       = PARITY_NONE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data_in,
  output logic       tx_out,
  output logic       tx_busy,
  output logic       tx_done
);

  // Unknown parity modes fall back to no parity bit.
  localparam logic PAR_EN   = (PARITY == PARITY_EVEN) || (PARITY == PARITY_ODD);
  localparam int   PAR_MODE = PAR_EN ? PARITY : PARITY_NONE;

  uart_state_t state;
  logic [7:0]  shift;
  logic [2:0]  bit_cnt;
  logic        par_bit;
  logic        accept;
  logic        bit_tick;

  assign accept = (state == ST_IDLE) && tx_start;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .en      (tx_busy),
    .load    (accept),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      tx_out  <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
      shift   <= '0;
      bit_cnt <= '0;
      par_bit <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          tx_out  <= 1'b1;
          tx_busy <= 1'b0;
          if (tx_start) begin
            shift   <= tx_data_in;
            par_bit <= parity_bit(tx_data_in, PAR_MODE);
            bit_cnt <= '0;
            tx_out  <= 1'b0;
            tx_busy <= 1'b1;
            state   <= ST_START;
          end
        end
        ST_START: begin
          if (bit_tick) begin
            tx_out <= shift[0];
            state  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            if (bit_cnt == 3'd7) begin
              if (PAR_EN) begin
                tx_out <= par_bit;
                state  <= ST_PARITY;
              end else begin
                tx_out <= 1'b1;
                state  <= ST_STOP;
              end
            end else begin
              // tx_out is registered, so it takes the bit that becomes shift[0] next.
              shift   <= {1'b0, shift[7:1]};
              tx_out  <= shift[1];
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        ST_PARITY: begin
          if (bit_tick) begin
            tx_out <= 1'b1;
            state  <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_tick) begin
            tx_busy <= 1'b0;
            tx_done <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: begin
          tx_out  <= 1'b1;
          tx_busy <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four instances (bit periods 4/2, no/even/odd parity) with
// randomized starts; a scoreboard replays each accepted frame against the recorded line.
`timescale 1ns/1ps
module tb_uart_tx_serializer;

  localparam int N    = 4;
  localparam int MAXC = 40000;

  logic       clk = 1'b0;
  logic       rst;
  logic       start [N];
  logic [7:0] din   [N];
  logic       line  [N];
  logic       busy  [N];
  logic       done  [N];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  int         last_t   [N];
  int         idle_bad [N];
  int         exp_t    [N][$];
  logic [7:0] exp_d    [N][$];
  logic       hl       [N][MAXC];
  logic       hb       [N][MAXC];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY(0)) u0 (
    .clk(clk), .rst(rst), .tx_start(start[0]), .tx_data_in(din[0]),
    .tx_out(line[0]), .tx_busy(busy[0]), .tx_done(done[0]));
  uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY(1)) u1 (
    .clk(clk), .rst(rst), .tx_start(start[1]), .tx_data_in(din[1]),
    .tx_out(line[1]), .tx_busy(busy[1]), .tx_done(done[1]));
  uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY(2)) u2 (
    .clk(clk), .rst(rst), .tx_start(start[2]), .tx_data_in(din[2]),
    .tx_out(line[2]), .tx_busy(busy[2]), .tx_done(done[2]));
  uart_tx_serializer #(.CLKS_PER_BIT(2), .PARITY(0)) u3 (
    .clk(clk), .rst(rst), .tx_start(start[3]), .tx_data_in(din[3]),
    .tx_out(line[3]), .tx_busy(busy[3]), .tx_done(done[3]));

  function automatic int cpb(input int i);
    return (i == 3) ? 2 : 4;
  endfunction

  function automatic int par(input int i);
    return (i == 1) ? 1 : (i == 2) ? 2 : 0;
  endfunction

  function automatic int flen(input int i);
    return (par(i) != 0 ? 11 : 10) * cpb(i);
  endfunction

  // Expected line level in bit slot k of a frame carrying d.
  function automatic logic exp_bit(input int i, input logic [7:0] d, input int k);
    int ones;
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (k == 9 && par(i) != 0) begin
      ones = $countones(d);
      if (par(i) == 1) return (ones % 2) == 1;
      return (ones % 2) == 0;
    end
    return 1'b1;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: actual %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Called at a negedge; the start is sampled on the following rising edge.
  task automatic send(input int i, input logic [7:0] d);
    start[i] = 1'b1;
    din[i]   = d;
    if (cyc >= last_t[i] + flen(i)) begin
      last_t[i] = cyc + 1;
      exp_t[i].push_back(cyc + 1);
      exp_d[i].push_back(d);
    end
    @(negedge clk);
    start[i] = 1'b0;
    din[i]   = 8'($urandom);
  endtask

  task automatic drive(input int i);
    send(i, 8'h3C);
    repeat (9) @(negedge clk);
    send(i, 8'hFF);
    wait_until(last_t[i] + flen(i)); send(i, 8'h01);
    wait_until(last_t[i] + flen(i)); send(i, 8'h80);
    wait_until(last_t[i] + flen(i)); send(i, 8'h00);
    wait_until(last_t[i] + flen(i)); send(i, 8'hFF);
    wait_until(last_t[i] + flen(i)); send(i, 8'hA5);
    wait_until(last_t[i] + flen(i) + 3); send(i, 8'h07);
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 3))
        0:       wait_until(last_t[i] + flen(i));
        1:       repeat ($urandom_range(0, flen(i) + 3)) @(negedge clk);
        default: repeat ($urandom_range(0, 6)) @(negedge clk);
      endcase
      send(i, 8'($urandom));
    end
  endtask

  task automatic monitor_step(input int i);
    int t, f, c, bad_line, bad_busy;
    logic [7:0] d;
    if (rst) begin
      exp_t[i].delete();
      exp_d[i].delete();
      return;
    end
    if (cyc >= MAXC) return;
    hl[i][cyc] = line[i];
    hb[i][cyc] = busy[i];
    if (!busy[i] && line[i] !== 1'b1) idle_bad[i]++;
    if (done[i] === 1'b1) begin
      if (exp_t[i].size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done dut%0d: done at cycle %0d, expected no done", i, cyc);
      end else begin
        t = exp_t[i].pop_front();
        d = exp_d[i].pop_front();
        f = flen(i);
        c = cpb(i);
        check($sformatf("done_time dut%0d data=%02h", i, d), cyc, t + f);
        bad_line = 0;
        bad_busy = 0;
        for (int k = 0; k < f; k++) begin
          if (t + k < MAXC) begin
            if (hl[i][t+k] !== exp_bit(i, d, k / c)) bad_line++;
            if (hb[i][t+k] !== 1'b1) bad_busy++;
          end
        end
        if (t >= 1) begin
          if (hl[i][t-1] !== 1'b1) bad_line++;
          if (hb[i][t-1] !== 1'b0) bad_busy++;
        end
        if (busy[i] !== 1'b0) bad_busy++;
        check($sformatf("frame_bits dut%0d data=%02h", i, d), bad_line, 0);
        check($sformatf("busy_span dut%0d data=%02h", i, d), bad_busy, 0);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) monitor_step(i);
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: reached cycle %0d, required finish before %0d", cyc, 60000);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      start[i] = 1'b0;
      din[i] = 8'h00;
      last_t[i] = -1000000;
      idle_bad[i] = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("reset_line dut%0d", i), int'(line[i]), 1);
      check($sformatf("reset_busy dut%0d", i), int'(busy[i]), 0);
      check($sformatf("reset_done dut%0d", i), int'(done[i]), 0);
    end
    rst = 1'b0;

    // Abort a frame of 0x55 midway with an asynchronous reset.
    @(negedge clk);
    for (int i = 0; i < N; i++) begin start[i] = 1'b1; din[i] = 8'h55; end
    @(negedge clk);
    for (int i = 0; i < N; i++) begin start[i] = 1'b0; din[i] = 8'($urandom); end
    repeat (14) @(negedge clk);
    check("busy_before_reset dut0", int'(busy[0]), 1);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("midframe_rst_line dut%0d", i), int'(line[i]), 1);
      check($sformatf("midframe_rst_busy dut%0d", i), int'(busy[i]), 0);
      check($sformatf("midframe_rst_done dut%0d", i), int'(done[i]), 0);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;

    fork
      drive(0);
      drive(1);
      drive(2);
      drive(3);
    join
    repeat (100) @(negedge clk);

    for (int i = 0; i < N; i++) begin
      check($sformatf("pending_frames dut%0d", i), exp_t[i].size(), 0);
      check($sformatf("idle_line_high dut%0d", i), idle_bad[i], 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
